rxpydecode: RTL and testbench

- Receive-side counterpart of the TX packet-type decoder.
- After the packet header has been accepted (HEC ok), it selects the payload layout from the received TYPE and the link mode, then runs over the decoded (post-FEC, de-whitened) bit stream.
- It parses the payload header, counts body bits and frames the CRC field. It also flags illegal lengths and signals end of payload to the RX datapath and the CRC checker.

---
 rtl/rxpydecode.sv | 208 ++++++++++++++++++++
 tb/tb_rxpydecode.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxpydecode.sv
// RX payload decoder: picks the payload layout from the received TYPE and link mode,
// then walks the decoded bit stream through voice, payload header, body and CRC phases.
module rxpydecode #(
    parameter int HDR_BITS_MAX = 16,
    parameter int CNT_W        = 13
) (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        header_done_p,
    input  logic [3:0]  rx_pk_type,
    input  logic        is_BRmode,
    input  logic        is_eSCO,
    input  logic        is_SCO,
    input  logic [9:0]  regi_esco_len,
    input  logic        rx_bit_valid,
    input  logic        rx_bit,
    input  logic        rx_abort,
    output logic [1:0]  py_llid,
    output logic        py_flow,
    output logic [9:0]  py_len,
    output logic [12:0] pylenbit_rx,
    output logic        py_hdr_valid_p,
    output logic        py_data_en,
    output logic        crc_en,
    output logic        py_done_p,
    output logic        len_err_p,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, VOICE, PYHDR, BODY, CRC} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [HDR_BITS_MAX-1:0] hdr_sr;
    logic                    hdr16;
    logic                    has_crc;
    logic [9:0]              max_len;

    // Layout selected by the incoming header; only consumed on header_done_p
    state_t      nx_state;
    logic        nx_hdr16;
    logic        nx_crc;
    logic        nx_null;
    logic [9:0]  nx_max;
    logic [9:0]  nx_len;
    logic [12:0] nx_bits;

    always_comb begin
        nx_state = IDLE;
        nx_hdr16 = 1'b0;
        nx_crc   = 1'b1;
        nx_null  = 1'b0;
        nx_max   = 10'd0;
        nx_len   = 10'd0;
        nx_bits  = 13'd0;
        case (rx_pk_type)
            4'h0, 4'h1: nx_null = 1'b1;
            4'h2: begin nx_state = BODY; nx_len = 10'd18; nx_bits = 13'd144; end
            4'h3: begin nx_state = PYHDR; nx_max = 10'd17; end
            4'h4: begin
                nx_state = PYHDR;
                nx_hdr16 = !is_BRmode;
                nx_max   = is_BRmode ? 10'd27 : 10'd54;
            end
            4'h5: begin nx_state = BODY; nx_crc = 1'b0; nx_len = 10'd10; nx_bits = 13'd80; end
            4'h6, 4'h7: begin
                if (is_eSCO) begin
                    nx_len   = regi_esco_len;
                    nx_bits  = {regi_esco_len, 3'b000};
                    nx_state = (regi_esco_len == 10'd0) ? CRC : BODY;
                end else begin
                    nx_state = BODY;
                    nx_crc   = 1'b0;
                    nx_len   = rx_pk_type[0] ? 10'd30 : 10'd20;
                    nx_bits  = rx_pk_type[0] ? 13'd240 : 13'd160;
                end
            end
            4'h8: begin
                if (is_SCO) begin
                    nx_state = VOICE;
                    nx_max   = 10'd9;
                end else begin
                    nx_state = PYHDR;
                    nx_hdr16 = 1'b1;
                    nx_max   = 10'd83;
                end
            end
            4'h9: begin nx_state = PYHDR; nx_crc = 1'b0; nx_max = 10'd29; end
            4'hA: begin nx_state = PYHDR; nx_hdr16 = 1'b1; nx_max = is_BRmode ? 10'd121 : 10'd367; end
            4'hB: begin nx_state = PYHDR; nx_hdr16 = 1'b1; nx_max = is_BRmode ? 10'd183 : 10'd552; end
            4'hE: begin nx_state = PYHDR; nx_hdr16 = 1'b1; nx_max = is_BRmode ? 10'd224 : 10'd679; end
            4'hF: begin nx_state = PYHDR; nx_hdr16 = 1'b1; nx_max = is_BRmode ? 10'd339 : 10'd1021; end
            default: begin
                nx_len   = regi_esco_len;
                nx_bits  = {regi_esco_len, 3'b000};
                nx_state = (regi_esco_len == 10'd0) ? CRC : BODY;
            end
        endcase
    end

    // Header bits arrive LSB first, so the oldest bit settles at the bottom of the window
    logic [HDR_BITS_MAX-1:0] hdr_word;
    logic [1:0]              hdr_llid;
    logic                    hdr_flow;
    logic [9:0]              hdr_len;
    logic                    hdr_last;

    assign hdr_word = {rx_bit, hdr_sr[HDR_BITS_MAX-1:1]};
    assign hdr_llid = hdr16 ? hdr_word[1:0] : hdr_word[9:8];
    assign hdr_flow = hdr16 ? hdr_word[2] : hdr_word[10];
    assign hdr_len  = hdr16 ? hdr_word[12:3] : {5'd0, hdr_word[15:11]};
    assign hdr_last = hdr16 ? (cnt == CNT_W'(15)) : (cnt == CNT_W'(7));

    assign busy       = (state != IDLE);
    assign py_data_en = rx_bit_valid & ((state == BODY) | (state == VOICE));
    assign crc_en     = rx_bit_valid & (state == CRC);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state          <= IDLE;
            cnt            <= '0;
            hdr_sr         <= '0;
            hdr16          <= 1'b0;
            has_crc        <= 1'b0;
            max_len        <= 10'd0;
            py_llid        <= 2'd0;
            py_flow        <= 1'b0;
            py_len         <= 10'd0;
            pylenbit_rx    <= 13'd0;
            py_hdr_valid_p <= 1'b0;
            py_done_p      <= 1'b0;
            len_err_p      <= 1'b0;
        end else begin
            py_hdr_valid_p <= 1'b0;
            py_done_p      <= 1'b0;
            len_err_p      <= 1'b0;
            if (rx_abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (header_done_p) begin
                state     <= nx_state;
                cnt       <= '0;
                hdr16     <= nx_hdr16;
                has_crc   <= nx_crc;
                max_len   <= nx_max;
                py_done_p <= nx_null;
                if (nx_state == BODY || nx_state == CRC) begin
                    py_len      <= nx_len;
                    pylenbit_rx <= nx_bits;
                end
            end else if (rx_bit_valid) begin
                case (state)
                    IDLE: ;
                    VOICE: begin
                        if (cnt == CNT_W'(79)) begin
                            cnt   <= '0;
                            state <= PYHDR;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PYHDR: begin
                        hdr_sr <= hdr_word;
                        if (hdr_last) begin
                            cnt            <= '0;
                            py_hdr_valid_p <= 1'b1;
                            py_llid        <= hdr_llid;
                            py_flow        <= hdr_flow;
                            py_len         <= hdr_len;
                            pylenbit_rx    <= {hdr_len, 3'b000};
                            if (hdr_len > max_len) begin
                                len_err_p <= 1'b1;
                                state     <= IDLE;
                            end else if (hdr_len == 10'd0) begin
                                state     <= has_crc ? CRC : IDLE;
                                py_done_p <= !has_crc;
                            end else begin
                                state <= BODY;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    BODY: begin
                        if (cnt == CNT_W'(pylenbit_rx - 13'd1)) begin
                            cnt       <= '0;
                            state     <= has_crc ? CRC : IDLE;
                            py_done_p <= !has_crc;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    CRC: begin
                        if (cnt == CNT_W'(15)) begin
                            cnt       <= '0;
                            state     <= IDLE;
                            py_done_p <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rxpydecode.sv
// Bench for rxpydecode: directed and randomized packets checked against a
// per-packet phase model built from the payload layout rules.
module tb_rxpydecode;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b0;
    logic        header_done_p = 1'b0;
    logic [3:0]  rx_pk_type = 4'd0;
    logic        is_BRmode = 1'b1;
    logic        is_eSCO = 1'b0;
    logic        is_SCO = 1'b0;
    logic [9:0]  regi_esco_len = 10'd0;
    logic        rx_bit_valid = 1'b0;
    logic        rx_bit = 1'b0;
    logic        rx_abort = 1'b0;
    logic [1:0]  py_llid;
    logic        py_flow;
    logic [9:0]  py_len;
    logic [12:0] pylenbit_rx;
    logic        py_hdr_valid_p;
    logic        py_data_en;
    logic        crc_en;
    logic        py_done_p;
    logic        len_err_p;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    int hv_n, hv_at, le_n, le_at, dn_n, dn_at;
    logic busy_any;

    rxpydecode dut (
        .clk_6M(clk_6M), .rstz(rstz), .header_done_p(header_done_p),
        .rx_pk_type(rx_pk_type), .is_BRmode(is_BRmode), .is_eSCO(is_eSCO),
        .is_SCO(is_SCO), .regi_esco_len(regi_esco_len), .rx_bit_valid(rx_bit_valid),
        .rx_bit(rx_bit), .rx_abort(rx_abort), .py_llid(py_llid), .py_flow(py_flow),
        .py_len(py_len), .pylenbit_rx(pylenbit_rx), .py_hdr_valid_p(py_hdr_valid_p),
        .py_data_en(py_data_en), .crc_en(crc_en), .py_done_p(py_done_p),
        .len_err_p(len_err_p), .busy(busy)
    );

    always #5 clk_6M = ~clk_6M;

    // Phase sizes for each TYPE/mode combination
    function automatic void layout(input logic [3:0] t, input logic br, input logic esco,
                                   input logic sco, input logic [9:0] elen, output bit nul,
                                   output int voice, output int hdr, output int crc,
                                   output int maxl, output int flen, output int fbits);
        nul = 0; voice = 0; hdr = 0; crc = 16; maxl = 0; flen = 0; fbits = 0;
        case (t)
            4'h0, 4'h1: begin nul = 1; crc = 0; end
            4'h2: begin flen = 18; fbits = 144; end
            4'h3: begin hdr = 8; maxl = 17; end
            4'h4: begin hdr = br ? 8 : 16; maxl = br ? 27 : 54; end
            4'h5: begin crc = 0; flen = 10; fbits = 80; end
            4'h6, 4'h7: begin
                if (esco) begin flen = elen; fbits = elen * 8; end
                else begin crc = 0; flen = (t == 4'h6) ? 20 : 30; fbits = flen * 8; end
            end
            4'h8: begin
                if (sco) begin voice = 80; hdr = 8; maxl = 9; end
                else begin hdr = 16; maxl = 83; end
            end
            4'h9: begin hdr = 8; crc = 0; maxl = 29; end
            4'hA: begin hdr = 16; maxl = br ? 121 : 367; end
            4'hB: begin hdr = 16; maxl = br ? 183 : 552; end
            4'hE: begin hdr = 16; maxl = br ? 224 : 679; end
            4'hF: begin hdr = 16; maxl = br ? 339 : 1021; end
            default: begin flen = elen; fbits = elen * 8; end
        endcase
    endfunction

    task automatic sample_pulses(input int idx);
        if (py_hdr_valid_p === 1'b1) begin hv_n++; hv_at = idx; end
        if (len_err_p === 1'b1) begin le_n++; le_at = idx; end
        if (py_done_p === 1'b1) begin dn_n++; dn_at = idx; end
        if (busy === 1'b1) busy_any = 1'b1;
    endtask

    task automatic clear_pulses();
        hv_n = 0; hv_at = -99; le_n = 0; le_at = -99; dn_n = 0; dn_at = -99;
        busy_any = 1'b0;
    endtask

    // Sends one whole packet (header_done_p, then every phase) and checks it against the model
    task automatic run_packet(input string tag, input logic [3:0] typ, input logic br,
                              input logic esco, input logic sco, input logic [9:0] elen,
                              input logic [1:0] llid, input logic flow, input int length,
                              input bit gaps);
        bit nul, err;
        int voice, hdr, crc, maxl, flen, fbits, len, body, total, de_bad, ce_bad;
        logic bits[$];
        logic [15:0] hw;
        logic exp_de, exp_ce;

        layout(typ, br, esco, sco, elen, nul, voice, hdr, crc, maxl, flen, fbits);
        if (hdr > 0) begin
            len = length; body = len * 8; err = (len > maxl);
        end else begin
            len = flen; body = fbits; err = 0;
        end
        total = nul ? 0 : (err ? voice + hdr : voice + hdr + body + crc);

        hw = 16'($urandom);
        if (hdr == 16) begin
            hw[1:0] = llid; hw[2] = flow; hw[12:3] = 10'(length);
        end else begin
            hw[1:0] = llid; hw[2] = flow; hw[7:3] = 5'(length);
        end
        for (int i = 0; i < voice; i++) bits.push_back(1'($urandom));
        for (int i = 0; i < hdr; i++) bits.push_back(hw[i]);
        while (bits.size() < total) bits.push_back(1'($urandom));

        clear_pulses();
        de_bad = 0; ce_bad = 0;
        @(negedge clk_6M);
        rx_pk_type = typ; is_BRmode = br; is_eSCO = esco; is_SCO = sco;
        regi_esco_len = elen; rx_bit_valid = 1'b0; header_done_p = 1'b1;
        @(negedge clk_6M);
        header_done_p = 1'b0;
        sample_pulses(-1);
        for (int i = 0; i < total; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    rx_bit_valid = 1'b0;
                    @(negedge clk_6M);
                    sample_pulses(i + 10000);
                end
            end
            rx_bit_valid = 1'b1;
            rx_bit = bits[i];
            #1;
            exp_de = (i < voice) || (i >= voice + hdr && i < voice + hdr + body);
            exp_ce = (crc > 0) && (i >= voice + hdr + body);
            if (py_data_en !== exp_de) de_bad++;
            if (crc_en !== exp_ce) ce_bad++;
            @(negedge clk_6M);
            sample_pulses(i);
        end
        rx_bit_valid = 1'b0;
        repeat (3) begin
            @(negedge clk_6M);
            sample_pulses(total + 20000);
        end

        vectors++;
        if (hv_n !== ((hdr > 0) ? 1 : 0) || (hdr > 0 && hv_at !== voice + hdr - 1)) begin
            miscompares++;
            $display("[TB] FAIL %s hdr_valid: got %0d pulses at %0d, expected %0d at %0d",
                     tag, hv_n, hv_at, (hdr > 0) ? 1 : 0, voice + hdr - 1);
        end
        vectors++;
        if (le_n !== (err ? 1 : 0) || (err && le_at !== voice + hdr - 1)) begin
            miscompares++;
            $display("[TB] FAIL %s len_err: got %0d pulses at %0d, expected %0d at %0d",
                     tag, le_n, le_at, err ? 1 : 0, voice + hdr - 1);
        end
        vectors++;
        if (dn_n !== (err ? 0 : 1) || (!err && dn_at !== total - 1)) begin
            miscompares++;
            $display("[TB] FAIL %s py_done: got %0d pulses at %0d, expected %0d at %0d",
                     tag, dn_n, dn_at, err ? 0 : 1, total - 1);
        end
        vectors++;
        if (de_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL %s py_data_en: got %0d wrong bits, expected 0", tag, de_bad);
        end
        vectors++;
        if (ce_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL %s crc_en: got %0d wrong bits, expected 0", tag, ce_bad);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s busy at end: got %0b expected 0", tag, busy);
        end
        if (nul) begin
            vectors++;
            if (busy_any !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s null busy: got %0b expected 0", tag, busy_any);
            end
        end else begin
            vectors++;
            if (py_len !== 10'(len) || pylenbit_rx !== 13'(len * 8)) begin
                miscompares++;
                $display("[TB] FAIL %s lengths: got %0d/%0d expected %0d/%0d",
                         tag, py_len, pylenbit_rx, len, len * 8);
            end
        end
        if (hdr > 0) begin
            vectors++;
            if (py_llid !== llid || py_flow !== flow) begin
                miscompares++;
                $display("[TB] FAIL %s llid/flow: got %0d/%0b expected %0d/%0b",
                         tag, py_llid, py_flow, llid, flow);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rstz = 1'b0;
        repeat (3) @(negedge clk_6M);
        vectors++;
        if ({py_llid, py_flow, py_len, pylenbit_rx, py_hdr_valid_p, py_done_p, len_err_p, busy} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset outputs: got len %0d bits %0d busy %0b, expected all 0",
                     py_len, pylenbit_rx, busy);
        end
        rstz = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_6M);
            rx_bit_valid = i[0];
            rx_bit = 1'($urandom);
            #1;
            if ({py_data_en, crc_en, py_hdr_valid_p, py_done_p, len_err_p, busy, py_len} !== '0) bad++;
        end
        rx_bit_valid = 1'b0;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL idle activity: got %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_directed();
        run_packet("dm1", 4'h3, 1, 0, 0, 10'd0, 2'd2, 1'b1, 10, 0);
        run_packet("dh5_edr_max", 4'hF, 0, 0, 0, 10'd0, 2'd1, 1'b0, 1021, 0);
        run_packet("dh5_edr_over", 4'hF, 0, 0, 0, 10'd0, 2'd3, 1'b1, 1022, 0);
        run_packet("hv3", 4'h7, 1, 0, 1, 10'd0, 2'd0, 1'b0, 0, 0);
        run_packet("esco_c", 4'hC, 1, 1, 0, 10'd120, 2'd0, 1'b0, 0, 0);
        run_packet("dv", 4'h8, 1, 0, 1, 10'd0, 2'd1, 1'b1, 5, 1);
        run_packet("null", 4'h0, 1, 0, 0, 10'd0, 2'd0, 1'b0, 0, 0);
        run_packet("dm1_len0", 4'h3, 1, 0, 0, 10'd0, 2'd1, 1'b0, 0, 1);
        run_packet("aux1_len0", 4'h9, 1, 0, 0, 10'd0, 2'd2, 1'b1, 0, 1);
        run_packet("dh1_max", 4'h4, 1, 0, 0, 10'd0, 2'd3, 1'b1, 27, 1);
        run_packet("dh1_over", 4'h4, 1, 0, 0, 10'd0, 2'd3, 1'b1, 28, 1);
    endtask

    task automatic test_abort();
        int bad;
        logic [7:0] hw;
        clear_pulses();
        hw = {5'd10, 1'b0, 2'd1};
        @(negedge clk_6M);
        rx_pk_type = 4'h3; is_BRmode = 1'b1; is_eSCO = 1'b0; is_SCO = 1'b0;
        header_done_p = 1'b1;
        @(negedge clk_6M);
        header_done_p = 1'b0;
        for (int i = 0; i < 28; i++) begin
            rx_bit_valid = 1'b1;
            rx_bit = (i < 8) ? hw[i] : 1'($urandom);
            @(negedge clk_6M);
        end
        rx_abort = 1'b1;
        @(negedge clk_6M);
        rx_abort = 1'b0;
        rx_bit_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort busy: got %0b expected 0", busy);
        end
        clear_pulses();
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            rx_bit_valid = 1'b1;
            rx_bit = 1'($urandom);
            #1;
            if (py_data_en !== 1'b0 || crc_en !== 1'b0) bad++;
            @(negedge clk_6M);
            sample_pulses(i);
        end
        rx_bit_valid = 1'b0;
        vectors++;
        if (bad !== 0 || dn_n !== 0 || busy_any !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort after: got %0d enables %0d done %0b busy, expected 0/0/0",
                     bad, dn_n, busy_any);
        end
        vectors++;
        if (py_len !== 10'd10 || py_llid !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL abort held fields: got len %0d llid %0d expected 10/1", py_len, py_llid);
        end

        clear_pulses();
        @(negedge clk_6M);
        rx_pk_type = 4'h3;
        header_done_p = 1'b1;
        rx_abort = 1'b1;
        @(negedge clk_6M);
        header_done_p = 1'b0;
        rx_abort = 1'b0;
        sample_pulses(-1);
        for (int i = 0; i < 20; i++) begin
            rx_bit_valid = 1'b1;
            rx_bit = 1'($urandom);
            @(negedge clk_6M);
            sample_pulses(i);
        end
        rx_bit_valid = 1'b0;
        vectors++;
        if (busy_any !== 1'b0 || hv_n !== 0 || dn_n !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort+header: got busy %0b hv %0d done %0d expected 0/0/0",
                     busy_any, hv_n, dn_n);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_6M);
        rx_pk_type = 4'hF; is_BRmode = 1'b0; is_eSCO = 1'b0; is_SCO = 1'b0;
        header_done_p = 1'b1;
        @(negedge clk_6M);
        header_done_p = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_bit_valid = 1'b1;
            rx_bit = 1'($urandom);
            @(negedge clk_6M);
        end
        rx_bit_valid = 1'b0;
        run_packet("restart_dm1", 4'h3, 1, 0, 0, 10'd0, 2'd2, 1'b0, 7, 1);
        run_packet("b2b_hv1", 4'h5, 1, 0, 1, 10'd0, 2'd0, 1'b0, 0, 0);
        run_packet("b2b_fhs", 4'h2, 1, 0, 0, 10'd0, 2'd0, 1'b0, 0, 1);
    endtask

    task automatic test_random();
        bit nul;
        int voice, hdr, crc, maxl, flen, fbits, length, cap;
        logic [3:0] typ;
        logic br, esco, sco;
        logic [9:0] elen;
        for (int n = 0; n < 30; n++) begin
            typ = 4'($urandom_range(0, 15));
            br = 1'($urandom);
            case ($urandom_range(0, 2))
                0: begin esco = 1'b0; sco = 1'b0; end
                1: begin esco = 1'b1; sco = 1'b0; end
                default: begin esco = 1'b0; sco = 1'b1; end
            endcase
            elen = 10'($urandom_range(0, 40));
            layout(typ, br, esco, sco, elen, nul, voice, hdr, crc, maxl, flen, fbits);
            cap = (hdr == 8) ? 31 : 1023;
            if ($urandom_range(0, 7) == 0) begin
                length = maxl + 1 + int'($urandom_range(0, 2));
                if (length > cap) length = cap;
            end else begin
                length = int'($urandom_range(0, (maxl < 40) ? maxl : 40));
            end
            run_packet($sformatf("rand%0d_t%0h", n, typ), typ, br, esco, sco, elen,
                       2'($urandom), 1'($urandom), length, 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
